// File: rtl/pwm_multi.sv
// pwm_multi: NCH-channel PWM generator sharing one free-running period counter, with
// shadow-buffered compare values. Define PWM_DEADTIME_EN for complementary outputs with dead-time.
module pwm_multi #(
  parameter int NCH      = 4,
  parameter int PERIOD   = 1000,
  parameter int CNT_W    = 10
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DEADTIME = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_tick
`ifdef PWM_DEADTIME_EN
  ,
  output logic [NCH-1:0]   pwm_n
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] wr_sat;
  logic             wr_hit;
  logic [NCH-1:0]   wr_sel;
  logic [NCH-1:0]   raw;
  logic [CNT_W-1:0] shadow [NCH];
  logic [CNT_W-1:0] active [NCH];

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // wr_en is a one-cycle write strobe with no back-pressure: every cycle it is high is one write.
  assign wr_sat = (wr_data > FULL) ? FULL : wr_data;
  assign wr_hit = wr_en && ({1'b0, wr_ch} < 5'(NCH));

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i] = wr_hit && (wr_ch == 4'(i));
    end
  end

  // A write landing in the wrap cycle goes straight into active so the next period uses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_sel[i]) begin
          shadow[i] <= wr_sat;
        end
        if (wrap) begin
          active[i] <= wr_sel[i] ? wr_sat : shadow[i];
        end
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NCH; i++) begin
      raw[i] = ch_en[i] && (cnt < active[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= (cnt == '0);
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [7:0] DT_LOAD = 8'(DEADTIME);

  logic [NCH-1:0] raw_q;
  logic [NCH-1:0] live;
  logic [7:0]     dt     [NCH];
  logic [7:0]     dt_nxt [NCH];

  // Any transition of raw restarts the dead window; both sides stay low until it drains.
  always_comb begin
    live = '0;
    for (int i = 0; i < NCH; i++) begin
      dt_nxt[i] = dt[i];
      if (raw[i] != raw_q[i]) begin
        dt_nxt[i] = DT_LOAD;
      end else if (dt[i] != 8'd0) begin
        dt_nxt[i] = dt[i] - 8'd1;
      end
      live[i] = (dt_nxt[i] == 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q   <= '0;
      pwm_out <= '0;
      pwm_n   <= '0;
      for (int i = 0; i < NCH; i++) begin
        dt[i] <= 8'd0;
      end
    end else begin
      raw_q   <= raw;
      pwm_out <= raw & live;
      pwm_n   <= ch_en & ~raw & live;
      for (int i = 0; i < NCH; i++) begin
        dt[i] <= dt_nxt[i];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= raw;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: cycle-by-cycle scoreboard against a behavioural model plus
// per-period high-time measurements for the directed scenarios.
module tb_pwm_multi;
  localparam int NCH    = 4;
  localparam int PERIOD = 1000;
  localparam int CNT_W  = 10;
`ifdef PWM_DEADTIME_EN
  localparam int DT = 4;
  localparam int OW = 1 + 2 * NCH;
`else
  localparam int OW = 1 + NCH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [CNT_W-1:0] wr_data;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   pwm_out;
  logic             period_tick;
`ifdef PWM_DEADTIME_EN
  logic [NCH-1:0]   pwm_n;
`endif

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  pwm_multi #(
    .NCH(NCH),
    .PERIOD(PERIOD),
    .CNT_W(CNT_W)
`ifdef PWM_DEADTIME_EN
    ,
    .DEADTIME(DT)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_data(wr_data),
    .ch_en(ch_en),
    .pwm_out(pwm_out),
    .period_tick(period_tick)
`ifdef PWM_DEADTIME_EN
    ,
    .pwm_n(pwm_n)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] obs();
`ifdef PWM_DEADTIME_EN
    return {pwm_n, period_tick, pwm_out};
`else
    return {period_tick, pwm_out};
`endif
  endfunction

  // behavioural model: evaluated on each active edge from the inputs held since the last negedge
  int               m_cnt;
  logic [CNT_W-1:0] m_sh  [NCH];
  logic [CNT_W-1:0] m_act [NCH];
`ifdef PWM_DEADTIME_EN
  int               m_dt  [NCH];
  logic [NCH-1:0]   m_prev;
`endif

  always @(posedge clk) begin
    logic [NCH-1:0] r;
    logic           tk;
    int             d;
`ifdef PWM_DEADTIME_EN
    logic [NCH-1:0] o;
    logic [NCH-1:0] n;
`endif
    if (reset) begin
      m_cnt = 0;
      for (int i = 0; i < NCH; i++) begin
        m_sh[i]  = '0;
        m_act[i] = '0;
      end
`ifdef PWM_DEADTIME_EN
      for (int i = 0; i < NCH; i++) m_dt[i] = 0;
      m_prev = '0;
`endif
      exp_q.push_back('0);
    end else begin
      for (int i = 0; i < NCH; i++) r[i] = ch_en[i] && (m_cnt < int'(m_act[i]));
      tk = (m_cnt == 0);
      d  = (int'(wr_data) > PERIOD) ? PERIOD : int'(wr_data);
      if (wr_en && int'(wr_ch) < NCH) m_sh[int'(wr_ch)] = CNT_W'(d);
      if (m_cnt == PERIOD - 1) begin
        for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
      end
      m_cnt = (m_cnt + 1) % PERIOD;
`ifdef PWM_DEADTIME_EN
      for (int i = 0; i < NCH; i++) begin
        if (r[i] != m_prev[i]) m_dt[i] = DT;
        else if (m_dt[i] != 0) m_dt[i] = m_dt[i] - 1;
        o[i] = (m_dt[i] == 0) && r[i];
        n[i] = (m_dt[i] == 0) && ch_en[i] && !r[i];
      end
      m_prev = r;
      exp_q.push_back({n, tk, o});
`else
      exp_q.push_back({tk, r});
`endif
    end
  end

  // scoreboard: compare each registered output against the model's prediction
  always @(negedge clk) begin
    if (exp_q.size() != 0) chk("sb", 32'(obs()), 32'(exp_q.pop_front()));
  end

  // driver tasks
  task automatic sync();
    int n = 0;
    while (period_tick !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    chk("sync", 32'(period_tick), 32'd1);
  endtask

  task automatic set_en(input logic [NCH-1:0] v);
    ch_en = v;
    @(negedge clk);
  endtask

  // Measures one full period of channel ch starting at a period_tick sample; optionally
  // issues one write (wch, wd) that the DUT samples while its counter equals wat (wat=0: none).
  task automatic measure(input int ch, input int wch, input int wat, input int wd,
                         output int hi, output int nhi, output int tk);
    int both;
    sync();
    hi = 0; nhi = 0; tk = 0; both = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_out[ch]) hi++;
      if (period_tick) tk++;
`ifdef PWM_DEADTIME_EN
      if (pwm_n[ch]) nhi++;
      if (pwm_out[ch] && pwm_n[ch]) both++;
`endif
      wr_en   = (wat > 0) && (i == wat - 1);
      wr_ch   = 4'(wch);
      wr_data = CNT_W'(wd);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("both_high", 32'(both), 32'd0);
  endtask

  initial begin
    int hi, nhi, tk;
    reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0; ch_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    reset = 1'b0;

`ifdef PWM_DEADTIME_EN
    ch_en = 4'b0010;
    measure(1, 1, 1, 500, hi, nhi, tk);
    chk("dt_pre", 32'(hi), 32'd0);
    measure(1, 0, 0, 0, hi, nhi, tk);
    chk("dt500_out", 32'(hi), 32'd496);
    chk("dt500_n", 32'(nhi), 32'd496);
    measure(1, 1, 300, 3, hi, nhi, tk);
    chk("dt500_out2", 32'(hi), 32'd496);
    measure(1, 0, 0, 0, hi, nhi, tk);
    chk("dt3_out", 32'(hi), 32'd0);
    chk("dt3_n", 32'(nhi), 32'd993);
    set_en(4'b1111);
    measure(2, 2, 100, 750, hi, nhi, tk);
    measure(0, 0, 100, 300, hi, nhi, tk);
`else
    ch_en = 4'b0001;
    measure(0, 0, 1, 500, hi, nhi, tk);
    chk("t1_pre", 32'(hi), 32'd0);
    measure(0, 0, 0, 0, hi, nhi, tk);
    chk("t1_hi", 32'(hi), 32'd500);
    chk("t1_tick", 32'(tk), 32'd1);
    measure(0, 0, 300, 200, hi, nhi, tk);
    chk("t2_cur", 32'(hi), 32'd500);
    measure(0, 0, 300, 0, hi, nhi, tk);
    chk("t2_next", 32'(hi), 32'd200);
    measure(0, 0, 300, 1000, hi, nhi, tk);
    chk("t3_zero", 32'(hi), 32'd0);
    measure(0, 0, 300, 1023, hi, nhi, tk);
    chk("t3_full", 32'(hi), 32'd1000);
    measure(0, 0, 0, 0, hi, nhi, tk);
    chk("t3_sat", 32'(hi), 32'd1000);
    set_en(4'b1111);
    measure(3, 7, 300, 300, hi, nhi, tk);
    measure(3, 0, 0, 0, hi, nhi, tk);
    chk("t4_badch", 32'(hi), 32'd0);
    measure(0, 0, 999, 300, hi, nhi, tk);
    chk("t4_wrap_cur", 32'(hi), 32'd1000);
    measure(0, 2, 100, 750, hi, nhi, tk);
    chk("t4_wrap_next", 32'(hi), 32'd300);
    measure(2, 0, 0, 0, hi, nhi, tk);
    chk("multi_ch2", 32'(hi), 32'd750);
    set_en(4'b1011);
    measure(2, 0, 0, 0, hi, nhi, tk);
    chk("en_off", 32'(hi), 32'd0);
    set_en(4'b1111);
    measure(2, 0, 0, 0, hi, nhi, tk);
    chk("en_on", 32'(hi), 32'd750);
`endif

    // reset pulse in the middle of a period, while ch2 is high
    sync();
    repeat (599) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", 32'(pwm_out), 32'd0);
    chk("rst_mid_tick", 32'(period_tick), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_restart_tick", 32'(period_tick), 32'd1);
    chk("rst_restart_out", 32'(pwm_out), 32'd0);
    measure(2, 0, 0, 0, hi, nhi, tk);
    chk("rst_cleared", 32'(hi), 32'd0);

    // random writes, channel indices (some invalid) and enables against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = 4'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       wr_data = '0;
        1:       wr_data = CNT_W'(PERIOD);
        2:       wr_data = '1;
        default: wr_data = CNT_W'($urandom_range(0, 1023));
      endcase
      if ($urandom_range(0, 199) == 0) ch_en = NCH'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
